// File: rtl/i2c_txn_seq.sv
// Register-transaction sequencer: expands one (dev, reg, rw, len) request into the
// START / WR / RESTART / RD / STOP command stream for the I2C byte-level master.
module i2c_txn_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             busy,
    output logic             done_tick,
    output logic             nack_err,
    output logic [2:0]       m_cmd,
    output logic [7:0]       m_din,
    output logic             m_wr,
    input  logic             m_ready,
    input  logic             m_ack,
    input  logic [7:0]       m_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [2:0] P_START   = 3'd0;
    localparam logic [2:0] P_ADDR_W  = 3'd1;
    localparam logic [2:0] P_REG     = 3'd2;
    localparam logic [2:0] P_RESTART = 3'd3;
    localparam logic [2:0] P_ADDR_R  = 3'd4;
    localparam logic [2:0] P_DATA_WR = 3'd5;
    localparam logic [2:0] P_DATA_RD = 3'd6;
    localparam logic [2:0] P_STOP    = 3'd7;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    logic [1:0]       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic             first_q, first_d;
    logic             rw_q, rw_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             nack_q, nack_d;

    logic       fire;
    logic       step_done;
    logic       last;
    logic       wr_step;
    logic [2:0] cmd;
    logic [7:0] din;

    always_comb begin
        cmd = CMD_START;
        din = 8'h00;
        case (step_q)
            P_START:   cmd = CMD_START;
            P_ADDR_W:  begin cmd = CMD_WR; din = {dev_q, 1'b0}; end
            P_REG:     begin cmd = CMD_WR; din = reg_q; end
            P_RESTART: cmd = CMD_RESTART;
            P_ADDR_R:  begin cmd = CMD_WR; din = {dev_q, 1'b1}; end
            P_DATA_WR: begin cmd = CMD_WR; din = wdata; end
            P_DATA_RD: begin cmd = CMD_RD; din = {7'd0, last}; end
            default:   cmd = CMD_STOP;
        endcase
    end

    // The first WAIT cycle is skipped because the master only drops ready a cycle after the strobe.
    assign last      = (cnt_q == LEN_W'(1));
    assign wr_step   = (step_q == P_ADDR_W) || (step_q == P_REG) ||
                       (step_q == P_ADDR_R) || (step_q == P_DATA_WR);
    assign fire      = (state_q == S_ISSUE) && m_ready &&
                       ((step_q != P_DATA_WR) || wdata_valid);
    assign step_done = (state_q == S_WAIT) && !first_q && m_ready;

    assign m_wr        = fire;
    assign m_cmd       = (state_q == S_ISSUE) ? cmd : 3'b000;
    assign m_din       = (state_q == S_ISSUE) ? din : 8'h00;
    assign wdata_ready = fire && (step_q == P_DATA_WR);
    assign done_tick   = step_done && (step_q == P_STOP);
    assign busy        = (state_q != S_IDLE);
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign nack_err    = nack_q;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        first_d  = first_q;
        rw_d     = rw_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        nack_d   = nack_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    dev_d   = dev_addr;
                    reg_d   = reg_addr;
                    cnt_d   = len;
                    nack_d  = 1'b0;
                    step_d  = P_START;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fire) begin
                    state_d = S_WAIT;
                    first_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (m_ready) begin
                    state_d = S_ISSUE;
                    case (step_q)
                        P_START:   step_d = P_ADDR_W;
                        P_ADDR_W:  step_d = P_REG;
                        P_REG:     step_d = (cnt_q == '0) ? P_STOP :
                                            (rw_q ? P_RESTART : P_DATA_WR);
                        P_RESTART: step_d = P_ADDR_R;
                        P_ADDR_R:  step_d = P_DATA_RD;
                        P_DATA_WR: begin
                            cnt_d  = cnt_q - LEN_W'(1);
                            step_d = last ? P_STOP : P_DATA_WR;
                        end
                        P_DATA_RD: begin
                            cnt_d    = cnt_q - LEN_W'(1);
                            rdata_d  = m_dout;
                            rvalid_d = 1'b1;
                            step_d   = last ? P_STOP : P_DATA_RD;
                        end
                        default:   state_d = S_IDLE;
                    endcase
                    // A NACK on any written byte abandons the rest of the sequence.
                    if (wr_step && m_ack) begin
                        nack_d = 1'b1;
                        step_d = P_STOP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            step_q   <= P_START;
            first_q  <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= 7'd0;
            reg_q    <= 8'd0;
            cnt_q    <= '0;
            rdata_q  <= 8'd0;
            rvalid_q <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            first_q  <= first_d;
            rw_q     <= rw_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            nack_q   <= nack_d;
        end
    end

endmodule

// File: tb/tb_i2c_txn_seq.sv
// Bench for i2c_txn_seq: a behavioural byte-master/slave model plus a command-list
// reference built from the transaction rules, with randomized latencies and data.
module tb_i2c_txn_seq;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] len = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       busy;
    logic       done_tick;
    logic       nack_err;
    logic [2:0] m_cmd;
    logic [7:0] m_din;
    logic       m_wr;
    logic       m_ready = 1'b1;
    logic       m_ack = 1'b0;
    logic [7:0] m_dout = 8'd0;

    int errors = 0;
    int checks = 0;

    bit         tRw;
    logic [6:0] tDev;
    logic [7:0] tReg;
    int         tLen;
    int         tNackAt;
    logic [7:0] wq[$];
    logic [7:0] rdSrc[$];

    logic [10:0] trace[$];
    logic [7:0]  rdObs[$];
    int wIdx = 0, rIdx = 0, wrCount = 0, readyCnt = 0, doneCnt = 0, wrViol = 0;

    int mPhase = 0, holdCnt = 0, blockReady = 0;
    bit pendAck = 0, pendRd = 0, stallW = 0, wRandom = 0;

    i2c_txn_seq #(.LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .len(len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
        .done_tick(done_tick), .nack_err(nack_err),
        .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr),
        .m_ready(m_ready), .m_ack(m_ack), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    // Master model: inputs change on the falling edge, outputs are observed 1 time unit later.
    always begin
        @(negedge clk);
        if (mPhase == 1) begin
            m_ready = 1'b1;
            mPhase  = 2;
        end else if (mPhase == 2) begin
            m_ready = 1'b0;
            if (holdCnt <= 1) mPhase = 3;
            else holdCnt--;
        end else if (mPhase == 3) begin
            m_ready = 1'b1;
            m_ack   = pendAck;
            if (pendRd) begin
                m_dout = (rIdx < rdSrc.size()) ? rdSrc[rIdx] : 8'hEE;
                rIdx++;
            end
            mPhase = 0;
        end else if (blockReady > 0) begin
            m_ready = 1'b0;
            blockReady--;
        end else begin
            m_ready = 1'b1;
        end
        if (wIdx < wq.size() && !stallW && (!wRandom || $urandom_range(0, 3) != 0)) begin
            wdata_valid = 1'b1;
            wdata       = wq[wIdx];
        end else begin
            wdata_valid = 1'b0;
            wdata       = 8'($urandom);
        end
        #1;
        if (!reset) begin
            mPhase     = 0;
            blockReady = 0;
        end else begin
            if (m_wr) begin
                trace.push_back({m_cmd, m_din});
                if (!m_ready || mPhase != 0) wrViol++;
                mPhase  = 1;
                holdCnt = 1 + int'($urandom_range(0, 2));
                pendAck = (m_cmd == CMD_WR) && (wrCount == tNackAt);
                pendRd  = (m_cmd == CMD_RD);
                if (m_cmd == CMD_WR) wrCount++;
            end
            if (wdata_ready) begin
                if (!(m_wr && m_cmd == CMD_WR && m_din == wdata && wdata_valid)) wrViol++;
                readyCnt++;
                wIdx++;
            end
            if (rdata_valid) rdObs.push_back(rdata);
            if (done_tick) doneCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit aRw, input logic [6:0] aDev, input logic [7:0] aReg,
                                 input int aLen, input int aNackAt, input bit randData);
        tRw = aRw; tDev = aDev; tReg = aReg; tLen = aLen; tNackAt = aNackAt;
        if (randData) begin
            wq.delete();
            rdSrc.delete();
            for (int i = 0; i < aLen; i++) begin
                wq.push_back(8'($urandom));
                rdSrc.push_back(8'($urandom));
            end
        end
        trace.delete();
        rdObs.delete();
        wIdx = 0; rIdx = 0; wrCount = 0; readyCnt = 0; doneCnt = 0; wrViol = 0;
        rw = aRw; dev_addr = aDev; reg_addr = aReg; len = 8'(aLen);
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        rw = ~aRw; dev_addr = 7'($urandom); reg_addr = 8'($urandom); len = 8'($urandom);
    endtask

    task automatic waitDone(input string tag, input int budget);
        int k = 0;
        while (doneCnt == 0 && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput({tag, " done_seen"}, 32'(doneCnt != 0), 32'd1);
        if (doneCnt == 0) begin
            reset = 1'b0;
            stepCycle();
            reset = 1'b1;
        end else begin
            stepCycle();
            checkOutput({tag, " idle_after_done"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic waitTrace(input string tag, input int n, input int budget);
        int k = 0;
        while (trace.size() < n && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput({tag, " trace_reached"}, 32'(trace.size() >= n), 32'd1);
    endtask

    function automatic logic [10:0] maskEntry(input logic [10:0] e);
        if (e[10:8] == CMD_WR) return e;
        if (e[10:8] == CMD_RD) return {e[10:8], 7'd0, e[0]};
        return {e[10:8], 8'h00};
    endfunction

    // Expected command list derived directly from the transaction rules.
    task automatic verifyTxn(input string tag);
        logic [10:0] exp[$];
        logic [7:0]  expRd[$];
        int wrIdx = 0;
        bit nacked = 0;
        int expReady = 0;
        exp.push_back({CMD_START, 8'h00});
        exp.push_back({CMD_WR, tDev, 1'b0});
        nacked = (wrIdx == tNackAt); wrIdx++;
        if (!nacked) begin
            exp.push_back({CMD_WR, tReg});
            nacked = (wrIdx == tNackAt); wrIdx++;
        end
        if (!nacked && tLen != 0) begin
            if (tRw) begin
                exp.push_back({CMD_RESTART, 8'h00});
                exp.push_back({CMD_WR, tDev, 1'b1});
                nacked = (wrIdx == tNackAt); wrIdx++;
                if (!nacked) begin
                    for (int i = 0; i < tLen; i++) begin
                        exp.push_back({CMD_RD, 7'd0, (i == tLen - 1)});
                        expRd.push_back(rdSrc[i]);
                    end
                end
            end else begin
                for (int i = 0; i < tLen && !nacked; i++) begin
                    exp.push_back({CMD_WR, wq[i]});
                    expReady++;
                    nacked = (wrIdx == tNackAt); wrIdx++;
                end
            end
        end
        exp.push_back({CMD_STOP, 8'h00});
        repeat (3) stepCycle();
        checkOutput({tag, " trace_len"}, 32'(trace.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < trace.size(); i++)
            checkOutput($sformatf("%s cmd[%0d]", tag, i), 32'(maskEntry(trace[i])), 32'(maskEntry(exp[i])));
        checkOutput({tag, " rdata_count"}, 32'(rdObs.size()), 32'(expRd.size()));
        for (int i = 0; i < expRd.size() && i < rdObs.size(); i++)
            checkOutput($sformatf("%s rdata[%0d]", tag, i), 32'(rdObs[i]), 32'(expRd[i]));
        checkOutput({tag, " wdata_ready_count"}, 32'(readyCnt), 32'(expReady));
        checkOutput({tag, " done_count"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, " nack_err"}, 32'(nack_err), 32'(nacked));
        checkOutput({tag, " handshake_violations"}, 32'(wrViol), 32'd0);
        checkOutput({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] i2c_txn_seq bench starting");
        tNackAt = -1;
        repeat (3) stepCycle();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset outputs", 32'({m_wr, m_cmd, m_din, rdata, rdata_valid, wdata_ready, done_tick, nack_err}), 32'd0);
        reset = 1'b1;
        stepCycle();

        wRandom = 0;
        wq = '{8'hA5, 8'h5A};
        applyStimulus(1'b0, 7'h48, 8'h01, 2, -1, 1'b0);
        waitDone("write", 500);
        verifyTxn("write");

        wq.delete();
        rdSrc = '{8'h11, 8'h22, 8'h33};
        wRandom = 1;
        applyStimulus(1'b1, 7'h1D, 8'h0F, 3, -1, 1'b0);
        repeat (5) stepCycle();
        rw = 1'b0; dev_addr = 7'h7F; reg_addr = 8'hEE; len = 8'd9;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        waitDone("read", 500);
        verifyTxn("read");

        applyStimulus(1'b0, 7'($urandom), 8'($urandom), 4, 0, 1'b1);
        waitDone("nack", 500);
        verifyTxn("nack");
        applyStimulus(1'b1, 7'($urandom), 8'($urandom), 2, -1, 1'b1);
        checkOutput("nack_clear nack_err", 32'(nack_err), 32'd0);
        checkOutput("nack_clear busy", 32'(busy), 32'd1);
        waitDone("after_nack", 500);
        verifyTxn("after_nack");

        wRandom = 0;
        stallW  = 1;
        applyStimulus(1'b0, 7'($urandom), 8'($urandom), 1, -1, 1'b1);
        waitTrace("stall", 3, 300);
        repeat (20) stepCycle();
        checkOutput("stall no_strobe", 32'(trace.size()), 32'd3);
        checkOutput("stall busy", 32'(busy), 32'd1);
        checkOutput("stall m_wr", 32'(m_wr), 32'd0);
        stallW = 0;
        stepCycle();
        checkOutput("stall release m_wr", 32'(m_wr), 32'd1);
        checkOutput("stall release wdata_ready", 32'(wdata_ready), 32'd1);
        blockReady = 5;
        begin
            int k = 0;
            while (blockReady > 0 && k < 100) begin
                stepCycle();
                k++;
            end
        end
        checkOutput("ready_block no_stop", 32'(trace.size()), 32'd4);
        waitDone("stall", 500);
        verifyTxn("stall");

        applyStimulus(1'b1, 7'($urandom), 8'($urandom), 0, -1, 1'b1);
        waitDone("len0_read", 500);
        verifyTxn("len0_read");

        wRandom = 1;
        for (int n = 0; n < 8; n++) begin
            bit rRw;
            int rLen, rNack;
            rRw   = 1'($urandom_range(0, 1));
            rLen  = int'($urandom_range(0, 4));
            rNack = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
            applyStimulus(rRw, 7'($urandom), 8'($urandom), rLen, rNack, 1'b1);
            waitDone($sformatf("rand%0d", n), 800);
            verifyTxn($sformatf("rand%0d", n));
        end

        wRandom = 0;
        applyStimulus(1'b1, 7'($urandom), 8'($urandom), 3, -1, 1'b1);
        waitTrace("rst_mid", 8, 400);
        reset = 1'b0;
        stepCycle();
        checkOutput("rst_mid busy", 32'(busy), 32'd0);
        checkOutput("rst_mid outputs", 32'({m_wr, m_cmd, m_din, rdata, rdata_valid, wdata_ready, done_tick, nack_err}), 32'd0);
        checkOutput("rst_mid rdata_count", 32'(rdObs.size()), 32'd2);
        reset = 1'b1;
        stepCycle();
        applyStimulus(1'b0, 7'($urandom), 8'($urandom), 2, -1, 1'b1);
        waitDone("post_reset", 500);
        verifyTxn("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_txn_seq.md
Name: i2c_txn_seq

Overview:
- Register-transaction sequencer that sits directly upstream of the I2C byte-level master in the I2C core. It drives that master's command/data/write-strobe inputs, replacing per-byte software command writes.
- Given a 7-bit device address, an 8-bit register address, a direction and a byte count, it issues the full START / address / register / [RESTART / address] / data / STOP command sequence autonomously.
- Write data enters on a valid/ready stream; read data leaves on a valid-pulse stream.

Parameters:
- LEN_W, 8, width of the byte-count input; max transfer = 2^LEN_W-1 bytes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- rw  in  1  1 = register read, 0 = register write; latched on start.
- dev_addr  in  7  slave address; latched on start.
- reg_addr  in  8  register/pointer byte; latched on start.
- len  in  LEN_W  data byte count; latched on start.
- wdata  in  8  write-data byte.
- wdata_valid  in  1  wdata available.
- wdata_ready  out  1  one-cycle pulse: wdata consumed this cycle.
- rdata  out  8  last read byte.
- rdata_valid  out  1  one-cycle pulse: rdata updated.
- busy  out  1  high whenever not IDLE.
- done_tick  out  1  one-cycle pulse when sequence ends (normal or error).
- nack_err  out  1  sticky; slave NACKed a written byte.
- m_cmd  out  3  master command: 000 START, 001 WR, 010 RD, 011 STOP, 100 RESTART.
- m_din  out  8  master data; for RD, bit0 = 1 sends NACK (last byte), 0 sends ACK.
- m_wr  out  1  one-cycle command strobe to master.
- m_ready  in  1  master idle and able to accept a command.
- m_ack  in  1  slave ack bit of last WR (0 = ACK).
- m_dout  in  8  byte received by last RD.

Behaviour:
- Reset (reset=0 at clk edge): state IDLE. All outputs 0 (m_cmd=000, m_din=0, rdata=0, nack_err=0). No STOP is issued on reset; bus recovery belongs to software.
- Each command step uses two sub-states:
  - ISSUE: when m_ready=1 (and, for data WR, wdata_valid=1), assert m_wr for exactly one cycle with m_cmd/m_din, then enter WAIT.
  - WAIT: ignore m_ready on its first cycle (the master drops ready one cycle after the strobe), then hold until m_ready=1 and advance.
- m_wr is never asserted while m_ready=0.
- Write sequence: START; WR {dev,0}; WR reg; len x WR wdata; STOP.
  - wdata_ready pulses in the same cycle as the m_wr of each data WR.
  - If wdata_valid=0, stay in ISSUE indefinitely. No timeout.
- Read sequence: START; WR {dev,0}; WR reg; RESTART; WR {dev,1}; len x RD; STOP.
  - m_din[0]=1 on the final RD, 0 on all earlier ones.
  - When each RD's WAIT completes: rdata <= m_dout, rdata_valid=1 for one cycle.
- len=0, either direction: START; WR {dev,0}; WR reg; STOP (pointer set only, no restart).
- NACK handling: on completion of any WR step with m_ack=1:
  - set nack_err=1, skip all remaining steps, issue STOP.
  - No further wdata_ready or rdata_valid pulses.
- Completion: done_tick pulses on the cycle the STOP step's WAIT completes; the next cycle is IDLE with busy=0.
- Byte counter: LEN_W bits, loaded with len, decremented per data byte; "last" means counter==1.
- start while busy: ignored, no effect on latched fields.
- Accepted start clears nack_err; busy=1 from the next cycle.
- start and reset in the same cycle: reset wins.

Test Plan:
- Write: dev=0x48, reg=0x01, len=2, wdata 0xA5, 0x5A always valid, model slave always ACKs -> m_cmd trace 000, 001(0x90), 001(0x01), 001(0xA5), 001(0x5A), 011; two wdata_ready pulses; one done_tick; nack_err=0.
- Read: dev=0x1D, reg=0x0F, rw=1, len=3, slave returns 0x11, 0x22, 0x33 -> trace 000, 001(0x3A), 001(0x0F), 100, 001(0x3B), 010(din0=0), 010(0), 010(1), 011; rdata_valid pulses carry 0x11, 0x22, 0x33 in order.
- NACK: write len=4, slave NACKs the address byte -> next command is STOP; nack_err=1; zero wdata_ready pulses; done_tick once; nack_err cleared by the next accepted start.
- Underflow/handshake: write len=1, wdata_valid held low 20 cycles after reg byte -> m_wr stays low, busy=1; data WR issues the cycle valid rises. Hold m_ready low 5 extra cycles -> no m_wr until m_ready=1.
- Boundaries: len=0 read -> 000, WR, WR, 011 (no 100, no RD). Second start pulsed mid-transfer -> ignored.
- Reset: reset low during the third read byte -> next cycle busy=0, m_wr=0, all outputs 0. A new start then runs a full sequence cleanly.
